// File: rtl/tone_meter_pkg.sv
// Shared definitions for the tone meter: FSM states, output range and the
// default system clock shared with the tone player.
package tone_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE
  } meter_state_t;

  localparam int unsigned     HZ_W           = 12;
  localparam logic [HZ_W-1:0] HZ_MAX         = 12'd4095;
  localparam int unsigned     DEFAULT_CLK_HZ = 100_000_000;

  function automatic logic [HZ_W-1:0] clamp_hz(input logic [31:0] q);
    return (q > 32'(HZ_MAX)) ? HZ_MAX : q[HZ_W-1:0];
  endfunction

  function automatic logic near_hz(input logic [HZ_W-1:0] a,
                                   input logic [HZ_W-1:0] b);
    logic [HZ_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return d <= HZ_W'(1);
  endfunction

endpackage

// File: rtl/seq_divider_u32.sv
// 32-bit unsigned restoring divider: one load cycle plus one quotient bit per
// clock (33 cycles per operation). A zero divisor yields an all-ones quotient.
module seq_divider_u32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [5:0]  step_q;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        take;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    shifted = {rem_q, quotient[31]};
    diff    = shifted - {1'b0, dvs_q};
    take    = shifted >= {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      dvs_q    <= '0;
      step_q   <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= '0;
        quotient <= dividend;
        dvs_q    <= divisor;
        step_q   <= 6'd32;
        busy     <= 1'b1;
      end else if (busy) begin
        rem_q    <= take ? diff[31:0] : shifted[31:0];
        quotient <= {quotient[30:0], take};
        step_q   <= step_q - 6'd1;
        if (step_q == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tone_meter.sv
// Square-wave frequency meter: hz = CLK_HZ / (clk cycles between rising edges).
// Optional input deglitch filter enabled by defining TONE_DEGLITCH_EN.
module tone_meter
  import tone_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned TIMEOUT_CYC = 100_000_000,
  parameter int unsigned GLITCH_CYC  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tone_in,
  output logic [HZ_W-1:0] hz,
  output logic            hz_valid,
  output logic            locked
);

  logic         sync_meta;
  logic         sync_q;
  logic         rise;
  logic [31:0]  period_cnt;
  logic [31:0]  period_q;
  logic         timed_out;
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic [31:0]  div_quotient;
  logic [HZ_W-1:0] new_hz;
  meter_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= tone_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef TONE_DEGLITCH_EN
  localparam int unsigned GCW = $clog2(GLITCH_CYC + 1);

  logic [GCW-1:0] glitch_cnt;
  logic           filt;
  logic           filt_d;

  // Level follows sync_q only after GLITCH_CYC consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
      filt       <= 1'b0;
      filt_d     <= 1'b0;
    end else begin
      filt_d <= filt;
      if (sync_q == filt) begin
        glitch_cnt <= '0;
      end else if (glitch_cnt == GCW'(GLITCH_CYC - 1)) begin
        filt       <= sync_q;
        glitch_cnt <= '0;
      end else begin
        glitch_cnt <= glitch_cnt + 1'b1;
      end
    end
  end

  assign rise = filt & ~filt_d;
`else
  logic sync_qq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_qq <= 1'b0;
    else        sync_qq <= sync_q;
  end

  assign rise = sync_q & ~sync_qq;

  // GLITCH_CYC is meaningful only when the filter is built in.
  if (GLITCH_CYC == 0) begin : g_no_filter
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        period_cnt <= '0;
    else if (rise)                     period_cnt <= 32'd1;
    else if (period_cnt < TIMEOUT_CYC) period_cnt <= period_cnt + 32'd1;
  end

  assign timed_out = period_cnt >= TIMEOUT_CYC;
  assign new_hz    = clamp_hz(div_quotient);

  seq_divider_u32 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (32'(CLK_HZ)),
    .divisor  (period_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Timeout wins over a finishing division; a rise during DIVIDE only
  // restarts the period counter, so that period is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hz        <= '0;
      hz_valid  <= 1'b0;
      locked    <= 1'b0;
      period_q  <= '0;
      div_start <= 1'b0;
    end else begin
      hz_valid  <= 1'b0;
      div_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            if (!div_busy) begin
              period_q  <= period_cnt;
              div_start <= 1'b1;
              state     <= DIVIDE;
            end
          end else if (timed_out) begin
            hz       <= '0;
            locked   <= 1'b0;
            hz_valid <= (hz != '0);
            state    <= IDLE;
          end
        end
        DIVIDE: begin
          if (timed_out) begin
            hz       <= '0;
            locked   <= 1'b0;
            hz_valid <= (hz != '0);
            state    <= IDLE;
          end else if (div_done) begin
            hz       <= new_hz;
            hz_valid <= 1'b1;
            locked   <= (hz != '0) && near_hz(new_hz, hz);
            state    <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_meter.sv
// Scoreboard bench for tone_meter: a period-level reference model predicts each
// hz_valid pulse (value, lock, cycle); a monitor process compares them.
module tb_tone_meter;

  localparam int unsigned TB_CLK_HZ  = 1_000_000;
  localparam int unsigned TB_TIMEOUT = 6000;
  localparam int unsigned TB_GLITCH  = 4;
`ifdef TONE_DEGLITCH_EN
  localparam int EDGE_LAT = 3 + TB_GLITCH;
`else
  localparam int EDGE_LAT = 3;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tone_in = 1'b0;
  logic [11:0] hz;
  logic        hz_valid;
  logic        locked;

  tone_meter #(
    .CLK_HZ      (TB_CLK_HZ),
    .TIMEOUT_CYC (TB_TIMEOUT),
    .GLITCH_CYC  (TB_GLITCH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tone_in  (tone_in),
    .hz       (hz),
    .hz_valid (hz_valid),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int hz;
    int lk;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: whether a reference edge exists, its cycle, last hz.
  bit m_active = 1'b0;
  int m_last   = 0;
  int m_hz     = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_hz(input int period);
    int q;
    q = int'(TB_CLK_HZ) / period;
    return (q > 4095) ? 4095 : q;
  endfunction

  task automatic model_edge(input int at);
    exp_t e;
    int   f;
    if (m_active) begin
      f    = ref_hz(at - m_last);
      e.hz = f;
      e.lk = (m_hz != 0 && (f - m_hz) <= 1 && (m_hz - f) <= 1) ? 1 : 0;
      e.at = at + EDGE_LAT + DIV_LAT;
      exp_q.push_back(e);
      m_hz = f;
    end
    m_active = 1'b1;
    m_last   = at;
  endtask

  task automatic model_timeout();
    exp_t e;
    if (m_active && m_hz != 0) begin
      e.hz = 0;
      e.lk = 0;
      e.at = m_last + EDGE_LAT + int'(TB_TIMEOUT);
      exp_q.push_back(e);
    end
    m_active = 1'b0;
    m_hz     = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tone_period(input int p);
    tone_in = 1'b1;
    model_edge(cyc);
    tick(p / 2);
    tone_in = 1'b0;
    tick(p - p / 2);
  endtask

  task automatic silence();
    tone_in = 1'b0;
    model_timeout();
    tick(int'(TB_TIMEOUT) + 200);
  endtask

`ifdef TONE_DEGLITCH_EN
  task automatic tone_period_glitch(input int p);
    tone_in = 1'b1;
    model_edge(cyc);
    tick(p / 2);
    tone_in = 1'b0;
    tick(p / 4);
    tone_in = 1'b1;
    tick(2);
    tone_in = 1'b0;
    tick(p - p / 2 - p / 4 - 2);
  endtask
`endif

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && hz_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hz_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("hz", int'(hz), e.hz);
        check("locked", int'(locked), e.lk);
        check("hz_valid_cycle", cyc, e.at);
      end
    end
  end

  initial begin : stim
    int p;
    int n;
    rst_n   = 1'b0;
    tone_in = 1'b0;
    tick(3);
    check("rst_hz", int'(hz), 0);
    check("rst_hz_valid", int'(hz_valid), 0);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1;
    tick(5);

    repeat (4) tone_period(2272);   // 440 Hz
    repeat (3) tone_period(1000);   // 1000 Hz
    repeat (3) tone_period(250);    // 4000 Hz
    silence();

    repeat (3) tone_period(100);    // 10 kHz, clamps
    repeat (3) tone_period(244);    // 4098 Hz, clamps
    repeat (3) tone_period(245);    // 4081 Hz, just below the clamp
    silence();

    // Reset while a division is in flight.
    repeat (3) tone_period(1000);
    tone_in = 1'b1;
    model_edge(cyc);
    tick(10);
    rst_n   = 1'b0;
    tone_in = 1'b0;
    #1;
    check("async_rst_hz", int'(hz), 0);
    check("async_rst_hz_valid", int'(hz_valid), 0);
    check("async_rst_locked", int'(locked), 0);
    void'(exp_q.pop_back());
    m_active = 1'b0;
    m_hz     = 0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    repeat (3) tone_period(500);

    for (int t = 0; t < 8; t++) begin
      p = int'($urandom_range(2000, 100));
      n = int'($urandom_range(4, 2));
      repeat (n) tone_period(p);
    end

`ifdef TONE_DEGLITCH_EN
    repeat (2) tone_period(1000);
    repeat (2) tone_period_glitch(1000);
    tone_period(1000);
`endif

    silence();

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    check("pending_expectations", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_meter.md
Name: tone_meter

Overview:
- Measures the frequency of a square-wave tone, e.g. the buzzer line or an external tone input, and reports it as an integer hz value.
- It is the inverse of the tone player: the player turns hz into a square wave, and this block turns the square wave back into hz.
- Used for player loop-back self-test and for pitch capture from a tone source.
- The period is measured in clk cycles between rising edges, then converted by a sequential divider: hz = CLK_HZ / period.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency; the dividend.
- TIMEOUT_CYC, 100_000_000: maximum period in clk cycles; no edge within this count means silence (hz = 0).
- GLITCH_CYC, 4: number of consecutive equal samples required by the deglitch filter; only used when TONE_DEGLITCH_EN is defined.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- tone_in, input, 1: asynchronous square-wave input.
- hz, output, 12: last measured frequency; 0 means silence.
- hz_valid, output, 1: one-cycle pulse when hz is updated, including updates to 0.
- locked, output, 1: high once two consecutive measurements agree within ±1 Hz; cleared on timeout.

Behaviour:
- Reset (rst_n low, asynchronous): hz=0, hz_valid=0, locked=0, state=IDLE, period counter=0, synchronizer flops=0.
- Input path: 2-FF synchronizer, then rising-edge detect (sync_q & ~sync_qq). Edge-to-detect latency is 3 clk.
- Period counter: 32 bits. Cleared to 1 on each detected rising edge, otherwise incremented. It saturates at TIMEOUT_CYC; it never wraps.
- States:
  - IDLE: wait for the first rising edge, then go to MEASURE (counter starts). No output change.
  - MEASURE, on a rising edge: latch period = counter, start the divider, go to DIVIDE.
  - MEASURE, counter reaches TIMEOUT_CYC: hz<=0, locked<=0, pulse hz_valid if hz was nonzero, go to IDLE.
  - DIVIDE: the divider runs CLK_HZ / period, 32-bit unsigned restoring division, 1 quotient bit per clk, 32 cycles plus 1 cycle to load. The period counter keeps running. On divider done:
    - hz <= (quotient > 4095) ? 4095 : quotient[11:0]
    - pulse hz_valid
    - locked <= (|new - old hz| <= 1) and old hz != 0
    - return to MEASURE.
- Edge during DIVIDE: the counter still clears (a new period begins) but no new division starts; that period is dropped. This cannot occur at or below 4095 Hz at 100 MHz (minimum period 24 420 cycles, far above 33).
- Timeout during DIVIDE: the divider result is discarded, and hz goes to 0 as above.
- period == 0 is impossible: the counter restarts at 1. Division by zero is unreachable; the divider still returns all-ones, which then clamps to 4095.
- Latency: hz_valid is asserted 34 clk after the rising edge that closes a period is detected.

Optional Feature:
- Macro: TONE_DEGLITCH_EN.
- Defined: a deglitch filter sits after the synchronizer. The filtered level changes only after GLITCH_CYC consecutive equal samples. Pulses shorter than GLITCH_CYC clk are ignored. Edge latency becomes 3+GLITCH_CYC clk, and the period measurement is unaffected in steady state.
- Not defined: no filter, and GLITCH_CYC is unused.

Decomposition:
- Shared package/header holds:
  - state encoding constants: IDLE, MEASURE, DIVIDE;
  - HZ_W = 12;
  - HZ_MAX = 4095;
  - the default CLK_HZ, shared with the tone player.
- One natural sub-module: seq_divider_u32. Interface: start, dividend, divisor, busy, done pulse, quotient; 33 cycles per operation. It is reusable elsewhere.

Test Plan:
- 440 Hz tone, half-period 113 636 clk (period 227 272) → after the second rising edge: hz=440, one hz_valid pulse; locked=1 after the third.
- 1000 Hz (period 100 000) then a switch to 4000 Hz (period 25 000) → hz 1000, then 4000 on the first full new period; locked drops for one update, then re-asserts.
- tone_in held low after a 1000 Hz run → hz=0, hz_valid pulse, locked=0 exactly TIMEOUT_CYC clk after the last detected edge.
- Period 10 000 clk (10 kHz) → hz clamps to 4095.
- rst_n asserted mid-DIVIDE → hz=0, hz_valid=0, locked=0 immediately (asynchronous); the next measurement after release is correct.
- With TONE_DEGLITCH_EN: a 2-clk glitch injected into a 1000 Hz tone → hz stays 1000. Without the macro, the same glitch produces a spurious short period, and hz reads ≥ 4095 or wrong.
